// File: rtl/rx_burst_ctrl.sv
// RX burst sequencer: discards ADC settling samples, forwards one I/Q burst to the
// datapath, then holds the datapath idle for a flush window before pulsing done.
module rx_burst_ctrl #(
  parameter int DW = 12,
  parameter int CW = 16,
  parameter int FW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [CW-1:0] i_cfg_settle,
  input  logic [CW-1:0] i_cfg_burst,
  input  logic [FW-1:0] i_cfg_flush,
  input  logic [DW-1:0] i_adc_i,
  input  logic [DW-1:0] i_adc_q,
  input  logic          i_adc_vld,
  output logic [DW-1:0] o_dp_i,
  output logic [DW-1:0] o_dp_q,
  output logic          o_dp_vld,
  output logic          o_flush,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_cnt,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_FLUSH   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [CW-1:0] settle_cnt_q, settle_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dp_i_q, dp_i_d;
  logic [DW-1:0] dp_q_q, dp_q_d;
  logic          dp_vld_q, dp_vld_d;
  logic          done_q, done_d;

  // One extra bit on the incremented counts keeps the terminal compare wrap-free.
  logic [CW:0] settle_nxt, cnt_nxt;
  logic [FW:0] flush_nxt;
  logic        settle_last, burst_last, flush_last;

  assign settle_nxt  = {1'b0, settle_cnt_q} + (CW+1)'(1);
  assign cnt_nxt     = {1'b0, cnt_q} + (CW+1)'(1);
  assign flush_nxt   = {1'b0, flush_cnt_q} + (FW+1)'(1);
  assign settle_last = (settle_nxt == {1'b0, settle_q});
  assign burst_last  = (cnt_nxt == {1'b0, burst_q});
  assign flush_last  = (flush_q == '0) || (flush_nxt == {1'b0, flush_q});

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d      = state_q;
    settle_d     = settle_q;
    burst_d      = burst_q;
    flush_d      = flush_q;
    settle_cnt_d = '0;
    flush_cnt_d  = '0;
    cnt_d        = cnt_q;
    dp_i_d       = dp_i_q;
    dp_q_d       = dp_q_q;
    dp_vld_d     = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          settle_d = i_cfg_settle;
          burst_d  = i_cfg_burst;
          flush_d  = i_cfg_flush;
          cnt_d    = '0;
          if (i_cfg_settle != '0)     state_d = S_SETTLE;
          else if (i_cfg_burst != '0) state_d = S_CAPTURE;
          else                        state_d = S_FLUSH;
        end
      end
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q;
        if (i_adc_vld) begin
          settle_cnt_d = settle_nxt[CW-1:0];
          if (settle_last) state_d = (burst_q != '0) ? S_CAPTURE : S_FLUSH;
        end
      end
      S_CAPTURE: begin
        if (i_adc_vld) begin
          dp_i_d   = i_adc_i;
          dp_q_d   = i_adc_q;
          dp_vld_d = 1'b1;
          cnt_d    = cnt_nxt[CW-1:0];
          if (burst_last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_nxt[FW-1:0];
        if (flush_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything the case decided; the abort-cycle sample is dropped.
    if (i_abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      settle_cnt_d = '0;
      flush_cnt_d  = '0;
      cnt_d        = cnt_q;
      dp_i_d       = dp_i_q;
      dp_q_d       = dp_q_q;
      dp_vld_d     = 1'b0;
      done_d       = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      burst_q      <= '0;
      flush_q      <= '0;
      settle_cnt_q <= '0;
      flush_cnt_q  <= '0;
      cnt_q        <= '0;
      dp_i_q       <= '0;
      dp_q_q       <= '0;
      dp_vld_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      burst_q      <= burst_d;
      flush_q      <= flush_d;
      settle_cnt_q <= settle_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      cnt_q        <= cnt_d;
      dp_i_q       <= dp_i_d;
      dp_q_q       <= dp_q_d;
      dp_vld_q     <= dp_vld_d;
      done_q       <= done_d;
    end
  end

  assign o_dp_i   = dp_i_q;
  assign o_dp_q   = dp_q_q;
  assign o_dp_vld = dp_vld_q;
  assign o_done   = done_q;
  assign o_cnt    = cnt_q;
  assign o_state  = state_q;
  assign o_busy   = (state_q != S_IDLE);
  assign o_flush  = (state_q == S_FLUSH);

endmodule
